// File: rtl/wave_gen_pkg.sv
// Shared types and constants for the wave_gen waveform generator.
package wave_gen_pkg;

  typedef enum logic [1:0] {
    MODE_TRI = 2'd0,
    MODE_SAW = 2'd1,
    MODE_SQR = 2'd2,
    MODE_DC  = 2'd3
  } mode_t;

  // Phase offset is an 8-bit value aligned to the top of the phase word.
  localparam int PHASE_OFF_W = 8;

  function automatic int ph_off_shift(input int dac_w);
    return dac_w - PHASE_OFF_W;
  endfunction

  function automatic logic [31:0] midscale(input int dac_w);
    return 32'd1 << (dac_w - 1);
  endfunction

endpackage

// File: rtl/wave_gen_shaper.sv
// Stage 2 of wave_gen: adds the phase offset, folds the phase into the
// selected shape and registers the offset-binary raw sample.
module wave_gen_shaper
  import wave_gen_pkg::*;
#(
  parameter int DAC_W = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DAC_W-1:0] phase,
  input  mode_t            mode,
  input  logic [7:0]       phase_off,
  output logic [DAC_W-1:0] raw
);

  localparam int               SHIFT = ph_off_shift(DAC_W);
  localparam logic [DAC_W-1:0] MID   = DAC_W'(midscale(DAC_W));

  logic [DAC_W-1:0] ph;
  logic [DAC_W-2:0] fold;
  logic [DAC_W-1:0] raw_next;

  assign ph   = phase + (DAC_W'(phase_off) << SHIFT);
  assign fold = ph[DAC_W-1] ? ~ph[DAC_W-2:0] : ph[DAC_W-2:0];

  always_comb begin
    raw_next = '0;
    case (mode)
      MODE_TRI: raw_next = {fold, 1'b0};
      MODE_SAW: raw_next = ph;
      MODE_SQR: raw_next = ph[DAC_W-1] ? '1 : '0;
      MODE_DC:  raw_next = MID;
      default:  raw_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) raw <= '0;
    else        raw <= raw_next;
  end

endmodule

// File: rtl/wave_gen.sv
// Phase-accumulator waveform generator with double-buffered configuration
// and a 3-stage pipeline to the DAC. WAVE_GEN_AMP_EN enables amplitude scaling.
module wave_gen
  import wave_gen_pkg::*;
#(
  parameter int DAC_W  = 14,
  parameter int ACC_W  = 24,
  parameter int FREQ_W = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              sync,
  input  logic              cfg_load,
  input  logic [1:0]        mode,
  input  logic [FREQ_W-1:0] freq_word,
  input  logic [7:0]        amp,
  input  logic [7:0]        phase_off,
  output logic              cfg_busy,
  output logic              wrap,
  output logic              dac_valid,
  output logic [DAC_W-1:0]  DAC_in
);

  logic [ACC_W-1:0]  acc;
  logic [ACC_W:0]    sum;
  logic              carry;
  logic              apply;
  logic              en_s1;
  logic              en_s2;
  logic [DAC_W-1:0]  raw;
  logic [DAC_W-1:0]  sample;

  mode_t             mode_pend;
  mode_t             mode_act;
  logic [FREQ_W-1:0] freq_pend;
  logic [FREQ_W-1:0] freq_act;
  logic [7:0]        off_pend;
  logic [7:0]        off_act;

  assign sum   = {1'b0, acc} + {1'b0, ACC_W'(freq_act)};
  assign carry = en & ~sync & sum[ACC_W];
  // Pending settings only swap in at a period boundary or while the output is idle.
  assign apply = cfg_busy & (carry | sync | ~en);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc   <= '0;
      wrap  <= 1'b0;
      en_s1 <= 1'b0;
      en_s2 <= 1'b0;
    end else begin
      en_s1 <= en;
      en_s2 <= en_s1;
      wrap  <= carry;
      if (sync)    acc <= '0;
      else if (en) acc <= sum[ACC_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfg_busy  <= 1'b0;
      mode_pend <= MODE_TRI;
      mode_act  <= MODE_TRI;
      freq_pend <= '0;
      freq_act  <= '0;
      off_pend  <= '0;
      off_act   <= '0;
    end else begin
      if (cfg_load) begin
        mode_pend <= mode_t'(mode);
        freq_pend <= freq_word;
        off_pend  <= phase_off;
      end
      if (apply) begin
        mode_act <= mode_pend;
        freq_act <= freq_pend;
        off_act  <= off_pend;
      end
      if (cfg_load)   cfg_busy <= 1'b1;
      else if (apply) cfg_busy <= 1'b0;
    end
  end

  wave_gen_shaper #(
    .DAC_W(DAC_W)
  ) u_shaper (
    .clk      (clk),
    .rst_n    (rst_n),
    .phase    (acc[ACC_W-1 -: DAC_W]),
    .mode     (mode_act),
    .phase_off(off_act),
    .raw      (raw)
  );

`ifdef WAVE_GEN_AMP_EN
  logic [7:0]               amp_pend;
  logic [7:0]               amp_act;
  logic [7:0]               amp_d;
  logic [8:0]               amp_p1;
  logic signed [9:0]        amp_s;
  logic signed [DAC_W-1:0]  s;
  logic signed [DAC_W+9:0]  prod;
  logic signed [DAC_W-1:0]  p;

  // amp_d travels with raw so a new gain lands on the same sample as a new shape.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      amp_pend <= '0;
      amp_act  <= '0;
      amp_d    <= '0;
    end else begin
      if (cfg_load) amp_pend <= amp;
      if (apply)    amp_act  <= amp_pend;
      amp_d <= amp_act;
    end
  end

  assign amp_p1 = {1'b0, amp_d} + 9'd1;
  assign amp_s  = $signed({1'b0, amp_p1});
  assign s      = $signed({~raw[DAC_W-1], raw[DAC_W-2:0]});
  assign prod   = (DAC_W+10)'(s) * (DAC_W+10)'(amp_s);
  assign p      = DAC_W'(prod >>> 8);
  assign sample = {~p[DAC_W-1], p[DAC_W-2:0]};
`else
  logic amp_unused;
  assign amp_unused = ^amp;
  assign sample     = raw;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dac_valid <= 1'b0;
      DAC_in    <= '0;
    end else begin
      dac_valid <= en_s2;
      DAC_in    <= en_s2 ? sample : '0;
    end
  end

endmodule

// File: tb/tb_wave_gen.sv
// Self-checking bench for wave_gen: static-phase vector table plus running
// sequences scored against a queue of expected DAC samples.
module tb_wave_gen;
  localparam int DAC_W  = 14;
  localparam int ACC_W  = 24;
  localparam int FREQ_W = 24;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic              sync;
  logic              cfg_load;
  logic [1:0]        mode;
  logic [FREQ_W-1:0] freq_word;
  logic [7:0]        amp;
  logic [7:0]        phase_off;
  logic              cfg_busy;
  logic              wrap;
  logic              dac_valid;
  logic [DAC_W-1:0]  DAC_in;

  always #5 clk = ~clk;

  wave_gen #(.DAC_W(DAC_W), .ACC_W(ACC_W), .FREQ_W(FREQ_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .sync     (sync),
    .cfg_load (cfg_load),
    .mode     (mode),
    .freq_word(freq_word),
    .amp      (amp),
    .phase_off(phase_off),
    .cfg_busy (cfg_busy),
    .wrap     (wrap),
    .dac_valid(dac_valid),
    .DAC_in   (DAC_in)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int               due;
    logic             valid;
    logic [DAC_W-1:0] dac;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [1:0]       mode;
    logic [7:0]       amp;
    logic [7:0]       off;
    logic [DAC_W-1:0] exp_amp;
    logic [DAC_W-1:0] exp_noamp;
  } vec_t;
  vec_t vecs[13];

  // model of active/pending configuration and accumulator
  logic [ACC_W-1:0]  m_acc;
  logic [1:0]        m_mode, p_mode;
  logic [FREQ_W-1:0] m_freq, p_freq;
  logic [7:0]        m_amp, p_amp, m_off, p_off;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [DAC_W-1:0] ref_sample(input logic [DAC_W-1:0] ph,
                                                  input logic [1:0] md, input logic [7:0] a);
    logic [DAC_W-1:0] r;
    int s, ai, p;
    case (md)
      2'd0:    r = ph[13] ? {~ph[12:0], 1'b0} : {ph[12:0], 1'b0};
      2'd1:    r = ph;
      2'd2:    r = ph[13] ? 14'h3FFF : 14'h0000;
      default: r = 14'h2000;
    endcase
`ifdef WAVE_GEN_AMP_EN
    s  = int'(r) - 8192;
    ai = int'(a);
    p  = (s * (ai + 1)) >>> 8;
    return 14'(p + 8192);
`else
    s = 0; ai = int'(a); p = s + ai;
    return r;
`endif
  endfunction

  function automatic bit model_carry();
    logic [ACC_W:0] s;
    s = {1'b0, m_acc} + {1'b0, ACC_W'(m_freq)};
    return en && !sync && s[ACC_W];
  endfunction

  task automatic set_cfg(input logic [1:0] md, input logic [FREQ_W-1:0] fw,
                         input logic [7:0] a, input logic [7:0] off);
    mode = md; freq_word = fw; amp = a; phase_off = off;
    p_mode = md; p_freq = fw; p_amp = a; p_off = off;
  endtask

  // One clock edge: advance the model, queue the sample due two edges later,
  // check wrap/busy and any sample due now.
  task automatic tick(input bit apply, input bit exp_busy);
    logic [ACC_W:0]   s;
    logic             exp_wrap;
    logic             en_now;
    logic [DAC_W-1:0] ph;
    exp_t             e;
    en_now   = en;
    s        = {1'b0, m_acc} + {1'b0, ACC_W'(m_freq)};
    exp_wrap = en && !sync && s[ACC_W];
    if (sync)    m_acc = '0;
    else if (en) m_acc = s[ACC_W-1:0];
    if (apply) begin
      m_mode = p_mode; m_freq = p_freq; m_amp = p_amp; m_off = p_off;
    end
    ph = m_acc[ACC_W-1 -: DAC_W] + {m_off, 6'b0};
    @(posedge clk);
    #1;
    cyc++;
    sb.push_back('{due: cyc + 2, valid: en_now,
                   dac: en_now ? ref_sample(ph, m_mode, m_amp) : '0});
    chk("wrap", wrap, exp_wrap);
    chk("cfg_busy", cfg_busy, exp_busy);
    while (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      chk("dac_valid", dac_valid, e.valid);
      chk("DAC_in", DAC_in, e.dac);
    end
  endtask

  initial begin
    bit found;
    int s_cyc;

    vecs[0]  = '{2'd0, 8'd255, 8'h00, 14'h0000, 14'h0000};
    vecs[1]  = '{2'd0, 8'd255, 8'h40, 14'h2000, 14'h2000};
    vecs[2]  = '{2'd0, 8'd255, 8'hC0, 14'h1FFE, 14'h1FFE};
    vecs[3]  = '{2'd1, 8'd255, 8'h80, 14'h2000, 14'h2000};
    vecs[4]  = '{2'd1, 8'd255, 8'hFF, 14'h3FC0, 14'h3FC0};
    vecs[5]  = '{2'd2, 8'd255, 8'h80, 14'h3FFF, 14'h3FFF};
    vecs[6]  = '{2'd2, 8'd255, 8'h7F, 14'h0000, 14'h0000};
    vecs[7]  = '{2'd3, 8'd255, 8'h55, 14'h2000, 14'h2000};
    vecs[8]  = '{2'd2, 8'd127, 8'hC0, 14'h2FFF, 14'h3FFF};
    vecs[9]  = '{2'd2, 8'd127, 8'h00, 14'h1000, 14'h0000};
    vecs[10] = '{2'd1, 8'd0,   8'hFF, 14'h201F, 14'h3FC0};
    vecs[11] = '{2'd1, 8'd0,   8'h00, 14'h1FE0, 14'h0000};
    vecs[12] = '{2'd0, 8'd63,  8'h40, 14'h2000, 14'h2000};

    // reset held with en and cfg_load active
    rst_n = 1'b0; en = 1'b1; sync = 1'b0; cfg_load = 1'b1;
    mode = 2'd2; freq_word = 24'd1024; amp = 8'd255; phase_off = 8'h40;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      chk("rst_DAC_in", DAC_in, 0);
      chk("rst_dac_valid", dac_valid, 0);
      chk("rst_wrap", wrap, 0);
      chk("rst_cfg_busy", cfg_busy, 0);
    end
    rst_n = 1'b1; cfg_load = 1'b0;
    m_acc = '0; m_mode = '0; m_freq = '0; m_amp = '0; m_off = '0;
    p_mode = '0; p_freq = '0; p_amp = '0; p_off = '0;
    sb.push_back('{due: cyc + 1, valid: 1'b0, dac: '0});
    sb.push_back('{due: cyc + 2, valid: 1'b0, dac: '0});

    // static-phase table: freq 0, config applied by sync
    foreach (vecs[i]) begin
      set_cfg(vecs[i].mode, '0, vecs[i].amp, vecs[i].off);
      cfg_load = 1'b1; tick(0, 1); cfg_load = 1'b0;
      sync = 1'b1; tick(1, 0); sync = 1'b0;
      tick(0, 0); tick(0, 0); tick(0, 0);
`ifdef WAVE_GEN_AMP_EN
      chk($sformatf("vec%0d", i), DAC_in, vecs[i].exp_amp);
`else
      chk($sformatf("vec%0d", i), DAC_in, vecs[i].exp_noamp);
`endif
    end

    // triangle, one phase LSB per cycle
    set_cfg(2'd0, 24'd1024, 8'd255, 8'h00);
    cfg_load = 1'b1; tick(0, 1); cfg_load = 1'b0;
    sync = 1'b1; tick(1, 0); sync = 1'b0;
    for (int k = 1; k < 10000; k++) tick(0, 0);

    // deferred frequency change, held until the carry edge
    set_cfg(2'd0, 24'd2048, 8'd255, 8'h00);
    cfg_load = 1'b1; tick(0, 1); cfg_load = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20000 && !found; k++) begin
      found = model_carry();
      tick(found, !found);
    end
    chk("carry_search1", found, 1);

    // load on a carry edge must stay pending
    found = 1'b0;
    for (int k = 0; k < 20000 && !found; k++) begin
      if (model_carry()) begin
        set_cfg(2'd1, 24'd1024, 8'd255, 8'h40);
        cfg_load = 1'b1; tick(0, 1); cfg_load = 1'b0;
        found = 1'b1;
      end else begin
        tick(0, 0);
      end
    end
    chk("carry_search2", found, 1);
    for (int k = 0; k < 5; k++) tick(0, 1);

    // sync applies the sawtooth with offset 0x40
    sync = 1'b1; tick(1, 0); sync = 1'b0;
    s_cyc = cyc;
    tick(0, 0); tick(0, 0);
    chk("sync_latency", cyc - s_cyc, 2);
    chk("sync_first", DAC_in, 14'h1000);
    for (int k = 0; k < 10; k++) tick(0, 0);

    // enable drop and resume
    en = 1'b0;
    for (int k = 0; k < 10; k++) tick(0, 0);
    chk("en_drop_DAC", DAC_in, 0);
    en = 1'b1;
    for (int k = 0; k < 10; k++) tick(0, 0);

    // reset mid-run with a pending configuration
    set_cfg(2'd2, 24'd4096, 8'd10, 8'h11);
    cfg_load = 1'b1; tick(0, 1); cfg_load = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    chk("midrst_DAC_in", DAC_in, 0);
    chk("midrst_dac_valid", dac_valid, 0);
    chk("midrst_wrap", wrap, 0);
    chk("midrst_cfg_busy", cfg_busy, 0);
    sb.delete();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
